// File: rtl/mem_access_ctrl_pkg.sv
// Shared state encodings and default timing constants for the memory access controller.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    MAC_IDLE = 2'd0,
    MAC_DATA = 2'd1,
    MAC_INST = 2'd2
  } mac_state_e;

  localparam int MAC_TMO_CYC = 255;
  localparam int MAC_TMO_W   = 8;

endpackage

// File: rtl/mac_timeout.sv
// Bus timeout counter: counts stalled cycles of an access and flags when the limit is reached.
module mac_timeout #(
  parameter int TMO_W   = 8,
  parameter int TMO_CYC = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == TMO_W'(TMO_CYC));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Serialises MEM-stage data accesses and IF-stage fetches onto one memory bus and
// produces memReady for the pipeline stall control. Data access always goes first.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = MAC_TMO_CYC,
  parameter int TMO_W   = MAC_TMO_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              memReady,
  output logic              bus_err
);

  mac_state_e        state_q, state_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic tmo_expired;
  logic acc_end;
  logic d_fin;
  logic i_fin;

  // An access ends on ack or on timeout; ack takes precedence for error reporting.
  assign acc_end  = bus_req_q && (bus_ack || tmo_expired);
  assign d_fin    = (state_q == MAC_DATA) && acc_end;
  assign i_fin    = (state_q == MAC_INST) && acc_end;
  assign bus_err  = bus_req_q && tmo_expired && !bus_ack;
  assign memReady = (!d_req || d_done_q || d_fin) && (!i_req || i_done_q || i_fin);

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

  mac_timeout #(
    .TMO_W  (TMO_W),
    .TMO_CYC(TMO_CYC)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clr    (!bus_req_q || acc_end),
    .en     (bus_req_q && !bus_ack),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    i_done_d    = i_done_q;
    d_done_d    = d_done_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    bus_req_d   = 1'b0;
    bus_we_d    = 1'b0;
    bus_addr_d  = '0;
    bus_wdata_d = '0;

    case (state_q)
      MAC_IDLE: begin
        if (d_req && !d_done_q) begin
          state_d = MAC_DATA;
        end else if (i_req && !i_done_q) begin
          state_d = MAC_INST;
        end
      end
      MAC_DATA: begin
        if (d_fin) begin
          state_d = (i_req && !i_done_q) ? MAC_INST : MAC_IDLE;
        end
      end
      MAC_INST: begin
        if (i_fin) begin
          state_d = MAC_IDLE;
        end
      end
      default: state_d = MAC_IDLE;
    endcase

    // A dropped data request still completes, but its load result is not kept.
    if (d_fin && bus_ack && d_req && !bus_we_q) begin
      d_rdata_d = bus_rdata;
    end
    if (i_fin && bus_ack) begin
      i_rdata_d = bus_rdata;
    end

    // Done flags hold until the pipeline advances, then re-arbitrate next cycle.
    if (memReady) begin
      d_done_d = 1'b0;
      i_done_d = 1'b0;
    end else begin
      d_done_d = d_done_q || d_fin;
      i_done_d = i_done_q || i_fin;
    end

    // Bus outputs are registered from the next-state decision.
    case (state_d)
      MAC_DATA: begin
        bus_req_d   = 1'b1;
        bus_we_d    = d_we;
        bus_addr_d  = d_addr;
        bus_wdata_d = d_wdata;
      end
      MAC_INST: begin
        bus_req_d  = 1'b1;
        bus_addr_d = i_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= MAC_IDLE;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

endmodule
